hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Sequencer for the multi-cycle multiply resource and the HI/LO register pair behind the ALU decoder.
//  Accepts ALU_MULT/ALU_MUL/ALU_MFHI/ALU_MFLO/ALU_MTHI/ALU_MTLO ops (Aluop.v encodings) from the EX stage.
//  Runs a radix-2 shift-add signed multiply and owns HI/LO.
//  Stalls the pipeline on HI/LO hazards and while a MUL result is outstanding.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH, split HI (upper) / LO (lower)
//  OPW    5   ALUop width
// PORTS
//  clk           in   1       system clock, all state updates on rising edge
//  rst_n         in   1       synchronous active-low reset
//  op_valid      in   1       EX-stage op present this cycle
//  alu_op        in   OPW     decoded ALUop
//  rs_val        in   WIDTH   operand A (MTHI/MTLO source)
//  rt_val        in   WIDTH   operand B
//  stall         out  1       combinational; hold EX and re-present the same op next cycle
//  busy          out  1       multiplier FSM not in IDLE
//  result        out  WIDTH   MFHI/MFLO/MUL result (registered)
//  result_valid  out  1       one-cycle pulse, result valid
//  hi, lo        out  WIDTH   architectural HI/LO (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; hi, lo, result, result_valid, busy = 0.
//   Aborts any in-flight multiply; no partial HI/LO write.
//  Own op: op_valid & alu_op in {MULT, MUL, MFHI, MFLO, MTHI, MTLO}.
//   All other ops are ignored and never stalled, except during MUL (below).
//  FSM: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  IDLE, own op accepted at edge E, stall=0:
//   MULT/MUL: latch |rs|, |rt|, sign = rs[W-1]^rt[W-1]; count=0; -> RUN.
//   MFHI/MFLO: result<=hi/lo; result_valid=1 for the cycle after E.
//   MTHI/MTLO: hi/lo<=rs_val; visible on hi/lo after E.
//  RUN: each cycle, if multiplier LSB set, add multiplicand to the upper accumulator;
//   shift {acc,mplr} right by 1; count++. At count==WIDTH-1 -> FIX.
//  FIX: negate the 2W product if sign=1.
//   MULT: {hi,lo}<=product.
//   MUL: result<=product[W-1:0], result_valid=1 next cycle; HI/LO unchanged.
//   -> IDLE.
//  Latency: MULT at edge E -> HI/LO updated at edge E+WIDTH+1; busy=1 over (E, E+WIDTH+1].
//  stall = busy & op_valid & own op (incl. in the FIX cycle; accepted the cycle after FIX).
//  MUL pending (MUL issued, result not yet returned): stall=1 regardless of op_valid/alu_op.
//   Drops in the cycle result_valid=1.
//  Arithmetic: unsigned magnitudes, so -2^(W-1) is handled (magnitude 2^(W-1) fits W bits).
//   Product wraps nothing: exact 2W-bit result.
//  Simultaneous: stalled ops have no side effect. Reset has priority over every event.
//  result holds its last value when result_valid=0.
// TESTING
//  1. Reset mid-RUN (cycle 10 of MULT) -> busy=0, hi=lo=0 next cycle; then MFLO returns 0.
//  2. MULT 7 * -3 -> after 33 cycles hi=FFFFFFFF, lo=FFFFFFEB; busy high exactly 33 cycles.
//  3. MULT 80000000*80000000 -> hi=40000000, lo=0. MFHI issued the next cycle:
//     stall=1 until FIX done, then result=40000000, result_valid one pulse.
//  4. MTHI 12345678 then MFHI back-to-back -> no stall; result=12345678 one cycle after MFHI.
//  5. MUL 0000FFFF*00010001 -> result=FFFFFFFF; stall high (even with op_valid=0) until result_valid;
//     HI/LO unchanged.
//  6. ADDU op presented during MULT RUN -> stall=0; MTLO during FIX -> stall=1, lo written only after IDLE.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair and radix-2 shift-add signed multiplier sequencer.
// Owns MULT/MUL/MFHI/MFLO/MTHI/MTLO and stalls EX on HI/LO hazards.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [OPW-1:0] ALU_MULT = OPW'(12);
    localparam logic [OPW-1:0] ALU_MUL  = OPW'(13);
    localparam logic [OPW-1:0] ALU_MFHI = OPW'(14);
    localparam logic [OPW-1:0] ALU_MFLO = OPW'(15);
    localparam logic [OPW-1:0] ALU_MTHI = OPW'(16);
    localparam logic [OPW-1:0] ALU_MTLO = OPW'(17);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplr;
    logic             sign;
    logic             is_mul;

    logic op_mult, op_mul, op_mfhi;
    logic op_mflo, op_mthi, op_mtlo;
    logic own, accept;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] fixed;

    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] v
    );
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_comb begin
        op_mult = 1'b0;
        op_mul  = 1'b0;
        op_mfhi = 1'b0;
        op_mflo = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        unique case (1'b1)
            (alu_op == ALU_MULT): op_mult = 1'b1;
            (alu_op == ALU_MUL):  op_mul  = 1'b1;
            (alu_op == ALU_MFHI): op_mfhi = 1'b1;
            (alu_op == ALU_MFLO): op_mflo = 1'b1;
            (alu_op == ALU_MTHI): op_mthi = 1'b1;
            (alu_op == ALU_MTLO): op_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign own = op_valid & (op_mult | op_mul | op_mfhi |
                             op_mflo | op_mthi | op_mtlo);

    assign busy   = (state != IDLE);
    assign accept = own & ~busy;
    // An outstanding MUL blocks every op until its result returns.
    assign stall  = busy & (own | is_mul);

    assign sum   = mplr[0] ? ({1'b0, acc} + {1'b0, mcand})
                           : {1'b0, acc};
    assign prod  = {acc, mplr};
    assign fixed = sign ? -prod : prod;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept & (op_mult | op_mul)) state_nx = RUN;
            RUN:  if (count == LAST) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= '0;
            mcand        <= '0;
            acc          <= '0;
            mplr         <= '0;
            sign         <= 1'b0;
            is_mul       <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept & (op_mult | op_mul)) begin
                        mcand  <= mag(rs_val);
                        mplr   <= mag(rt_val);
                        acc    <= '0;
                        sign   <= rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
                        count  <= '0;
                        is_mul <= op_mul;
                    end
                    if (accept & op_mfhi) begin
                        result       <= hi;
                        result_valid <= 1'b1;
                    end
                    if (accept & op_mflo) begin
                        result       <= lo;
                        result_valid <= 1'b1;
                    end
                    if (accept & op_mthi) hi <= rs_val;
                    if (accept & op_mtlo) lo <= rs_val;
                end
                RUN: begin
                    acc   <= sum[WIDTH:1];
                    mplr  <= {sum[0], mplr[WIDTH-1:1]};
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (is_mul) begin
                        result       <= fixed[WIDTH-1:0];
                        result_valid <= 1'b1;
                    end else begin
                        hi <= fixed[2*WIDTH-1:WIDTH];
                        lo <= fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: vector table with a result scoreboard,
// plus directed sequences for reset, stall and timing corners.
module tb_hilo_muldiv_ctrl;

    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADDU = 5'd1;
    localparam logic [4:0] ALU_MULT = 5'd12;
    localparam logic [4:0] ALU_MUL  = 5'd13;
    localparam logic [4:0] ALU_MFHI = 5'd14;
    localparam logic [4:0] ALU_MFLO = 5'd15;
    localparam logic [4:0] ALU_MTHI = 5'd16;
    localparam logic [4:0] ALU_MTLO = 5'd17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [4:0]  alu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_muldiv_ctrl #(.WIDTH(32), .OPW(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .alu_op       (alu_op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        has_res;
        logic [31:0] res;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t        vecs[15];
    logic [31:0] sb[$];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                chk("result", result, sb.pop_front());
            end
        end
    end

    task automatic do_op(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic has_res,
                         input logic [31:0] res, output int stalls);
        @(negedge clk);
        op_valid = 1'b1;
        alu_op   = op;
        rs_val   = a;
        rt_val   = b;
        stalls   = 0;
        #1;
        while (stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stall) chk("accept_timeout", 32'd1, 32'd0);
        if (has_res) sb.push_back(res);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        alu_op   = ALU_NOP;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int st;
        int n;

        vecs[0]  = '{ALU_MTHI, 32'h12345678, 32'h0, 1'b0, 32'h0,
                     32'h12345678, 32'h00000000};
        vecs[1]  = '{ALU_MTLO, 32'h9abcdef0, 32'h0, 1'b0, 32'h0,
                     32'h12345678, 32'h9abcdef0};
        vecs[2]  = '{ALU_MFHI, 32'h0, 32'h0, 1'b1, 32'h12345678,
                     32'h12345678, 32'h9abcdef0};
        vecs[3]  = '{ALU_MFLO, 32'h0, 32'h0, 1'b1, 32'h9abcdef0,
                     32'h12345678, 32'h9abcdef0};
        vecs[4]  = '{ALU_MULT, 32'h00000007, 32'hfffffffd, 1'b0, 32'h0,
                     32'hffffffff, 32'hffffffeb};
        vecs[5]  = '{ALU_MULT, 32'h80000000, 32'h80000000, 1'b0, 32'h0,
                     32'h40000000, 32'h00000000};
        vecs[6]  = '{ALU_MULT, 32'h80000000, 32'h00000001, 1'b0, 32'h0,
                     32'hffffffff, 32'h80000000};
        vecs[7]  = '{ALU_MULT, 32'hffffffff, 32'hffffffff, 1'b0, 32'h0,
                     32'h00000000, 32'h00000001};
        vecs[8]  = '{ALU_MULT, 32'h00010000, 32'h00010000, 1'b0, 32'h0,
                     32'h00000001, 32'h00000000};
        vecs[9]  = '{ALU_MUL, 32'h0000ffff, 32'h00010001, 1'b1,
                     32'hffffffff, 32'h00000001, 32'h00000000};
        vecs[10] = '{ALU_MUL, 32'hfffffffe, 32'h00000003, 1'b1,
                     32'hfffffffa, 32'h00000001, 32'h00000000};
        vecs[11] = '{ALU_MULT, 32'h7fffffff, 32'h7fffffff, 1'b0, 32'h0,
                     32'h3fffffff, 32'h00000001};
        vecs[12] = '{ALU_MFHI, 32'h0, 32'h0, 1'b1, 32'h3fffffff,
                     32'h3fffffff, 32'h00000001};
        vecs[13] = '{ALU_MULT, 32'h00000000, 32'h00012345, 1'b0, 32'h0,
                     32'h00000000, 32'h00000000};
        vecs[14] = '{ALU_ADDU, 32'h11111111, 32'h22222222, 1'b0, 32'h0,
                     32'h00000000, 32'h00000000};

        rst_n    = 1'b0;
        op_valid = 1'b0;
        alu_op   = ALU_NOP;
        rs_val   = '0;
        rt_val   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].has_res, vecs[i].res, st);
            wait_idle();
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
        end

        // MTHI then MFHI in consecutive cycles
        do_op(ALU_MTHI, 32'h12345678, 32'h0, 1'b0, 32'h0, st);
        chk("mthi_stall", st, 0);
        do_op(ALU_MFHI, 32'h0, 32'h0, 1'b1, 32'h12345678, st);
        chk("mfhi_b2b_stall", st, 0);
        wait_idle();

        // MULT 7 * -3: busy width
        do_op(ALU_MULT, 32'h7, 32'hfffffffd, 1'b0, 32'h0, st);
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mult_busy_cycles", n, 33);
        chk("mult_neg_hi", hi, 32'hffffffff);
        chk("mult_neg_lo", lo, 32'hffffffeb);

        // MFHI right behind MULT is held until FIX completes
        do_op(ALU_MULT, 32'h80000000, 32'h80000000, 1'b0, 32'h0, st);
        do_op(ALU_MFHI, 32'h0, 32'h0, 1'b1, 32'h40000000, st);
        chk("mfhi_hazard_stalls", st, 33);
        wait_idle();
        chk("minmin_hi", hi, 32'h40000000);
        chk("minmin_lo", lo, 32'h00000000);

        // MUL holds the pipe even with no op, ADDU included
        do_op(ALU_MUL, 32'h0000ffff, 32'h00010001, 1'b1, 32'hffffffff,
              st);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (result_valid) break;
            if (k == 5) begin
                op_valid = 1'b1;
                alu_op   = ALU_ADDU;
                #1;
                chk("mul_addu_stall", {31'd0, stall}, 32'd1);
                op_valid = 1'b0;
                alu_op   = ALU_NOP;
            end
            if (stall) n++;
        end
        chk("mul_rv_seen", {31'd0, result_valid}, 32'd1);
        chk("mul_stall_drop", {31'd0, stall}, 32'd0);
        chk("mul_stall_cycles", n, 33);
        wait_idle();
        chk("mul_hi_keep", hi, 32'h40000000);
        chk("mul_lo_keep", lo, 32'h00000000);

        // ADDU during RUN passes; MTLO during FIX waits for IDLE
        do_op(ALU_MULT, 32'h3, 32'h5, 1'b0, 32'h0, st);
        repeat (5) @(negedge clk);
        op_valid = 1'b1;
        alu_op   = ALU_ADDU;
        #1;
        chk("addu_run_stall", {31'd0, stall}, 32'd0);
        op_valid = 1'b0;
        alu_op   = ALU_NOP;
        repeat (28) @(negedge clk);
        op_valid = 1'b1;
        alu_op   = ALU_MTLO;
        rs_val   = 32'h13572468;
        #1;
        chk("mtlo_fix_stall", {31'd0, stall}, 32'd1);
        chk("mtlo_fix_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("mtlo_fix_lo_mult", lo, 32'h0000000f);
        chk("mtlo_fix_hi_mult", hi, 32'h00000000);
        @(posedge clk);
        #1;
        chk("mtlo_after_lo", lo, 32'h13572468);
        op_valid = 1'b0;
        alu_op   = ALU_NOP;
        wait_idle();

        // Reset ten cycles into a MULT
        do_op(ALU_MULT, 32'h5, 32'h6, 1'b0, 32'h0, st);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(ALU_MFLO, 32'h0, 32'h0, 1'b1, 32'h0, st);
        chk("midrst_mflo_stall", st, 0);
        wait_idle();
        chk("post_rst_lo", lo, 32'd0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
